// File: rtl/bus_pkg.sv
// Shared types and constants for the core data-side bus bridge.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DMEM_WAIT,
        ACC_REQ,
        ACC_RSP,
        ERR_RSP
    } bridge_state_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DMEM,
        REG_ACC
    } region_e;

    // Data returned to the core on an unmapped access or accelerator timeout.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bridge_addr_decode.sv
// Address decoder: maps a core byte address onto a slave region and window offsets.
module bridge_addr_decode
    import bus_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
    parameter int          DMEM_AW   = 14,
    parameter logic [31:0] ACC_BASE  = 32'h8000_0000,
    parameter int          ACC_AW    = 12
) (
    input  logic [31:0]        mem_addr,
    output region_e            region,
    output logic [DMEM_AW-3:0] dmem_word,
    output logic [ACC_AW-1:0]  acc_offset
);

    // Window match on the bits above each window size; the RAM wins if the windows overlap.
    always_comb begin
        region = REG_NONE;
        if ((mem_addr >> DMEM_AW) == (DMEM_BASE >> DMEM_AW)) begin
            region = REG_DMEM;
        end else if ((mem_addr >> ACC_AW) == (ACC_BASE >> ACC_AW)) begin
            region = REG_ACC;
        end
    end

    assign dmem_word  = mem_addr[DMEM_AW-1:2];
    assign acc_offset = mem_addr[ACC_AW-1:0];

endmodule

// File: rtl/core_bus_bridge.sv
// Core load/store bridge: routes single requests to the data RAM or the accelerator window.
module core_bus_bridge
    import bus_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
    parameter int          DMEM_AW   = 14,
    parameter logic [31:0] ACC_BASE  = 32'h8000_0000,
    parameter int          ACC_AW    = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                mem_rd_wr,
    input  logic [3:0]          mask,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_write_data,
    output logic [31:0]         mem_read_data,
    output logic                mem_valid,
    output logic                bus_err,
    output logic                dmem_en,
    output logic [3:0]          dmem_we,
    output logic [DMEM_AW-3:0]  dmem_addr,
    output logic [31:0]         dmem_wdata,
    input  logic [31:0]         dmem_rdata,
    output logic                acc_req_valid,
    input  logic                acc_req_ready,
    output logic                acc_we,
    output logic [3:0]          acc_mask,
    output logic [ACC_AW-1:0]   acc_addr,
    output logic [31:0]         acc_wdata,
    input  logic                acc_rsp_valid,
    input  logic [31:0]         acc_rdata
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bridge_state_e       state_q, state_d;
    logic                we_q, we_d;
    logic [3:0]          mask_q, mask_d;
    logic [ACC_AW-1:0]   offset_q, offset_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    region_e             region;
    logic [DMEM_AW-3:0]  dmem_word;
    logic [ACC_AW-1:0]   acc_offset;

    bridge_addr_decode #(
        .DMEM_BASE (DMEM_BASE),
        .DMEM_AW   (DMEM_AW),
        .ACC_BASE  (ACC_BASE),
        .ACC_AW    (ACC_AW)
    ) u_decode (
        .mem_addr   (mem_addr),
        .region     (region),
        .dmem_word  (dmem_word),
        .acc_offset (acc_offset)
    );

    // Next-state, request capture and timeout counting; timeout beats a same-cycle handshake.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        mask_d   = mask_q;
        offset_d = offset_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (cs) begin
                    we_d     = ~mem_rd_wr;
                    mask_d   = mask;
                    offset_d = acc_offset;
                    wdata_d  = mem_write_data;
                    cnt_d    = '0;
                    case (region)
                        REG_DMEM: state_d = DMEM_WAIT;
                        REG_ACC:  state_d = ACC_REQ;
                        default:  state_d = ERR_RSP;
                    endcase
                end
            end
            DMEM_WAIT: state_d = IDLE;
            ACC_REQ: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = ERR_RSP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (acc_req_ready) begin
                        state_d = ACC_RSP;
                    end
                end
            end
            ACC_RSP: begin
                if (acc_rsp_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERR_RSP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ERR_RSP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        mem_read_data = '0;
        mem_valid     = 1'b0;
        bus_err       = 1'b0;
        dmem_en       = 1'b0;
        dmem_we       = '0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        acc_req_valid = 1'b0;
        acc_we        = 1'b0;
        acc_mask      = '0;
        acc_addr      = '0;
        acc_wdata     = '0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (cs && (region == REG_DMEM)) begin
                        dmem_en    = 1'b1;
                        dmem_we    = mem_rd_wr ? 4'b0000 : mask;
                        dmem_addr  = dmem_word;
                        dmem_wdata = mem_write_data;
                    end
                end
                DMEM_WAIT: begin
                    mem_valid     = 1'b1;
                    mem_read_data = we_q ? 32'h0 : dmem_rdata;
                end
                ACC_REQ: begin
                    acc_req_valid = 1'b1;
                    acc_we        = we_q;
                    acc_mask      = mask_q;
                    acc_addr      = offset_q;
                    acc_wdata     = wdata_q;
                end
                ACC_RSP: begin
                    if (acc_rsp_valid) begin
                        mem_valid     = 1'b1;
                        mem_read_data = we_q ? 32'h0 : acc_rdata;
                    end
                end
                ERR_RSP: begin
                    mem_valid     = 1'b1;
                    bus_err       = 1'b1;
                    mem_read_data = ERR_DATA;
                end
                default: begin
                    mem_valid = 1'b0;
                end
            endcase
        end
    end

    // State, capture and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            mask_q   <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            mask_q   <= mask_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
